display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scheduler for the calculator's 4-digit common-anode seven-segment display. It generates its own scan tick from the system clock as a clock-enable, not a derived clock. It sequences one digit at a time with a dead-time blanking gap and double-buffers the displayed value so updates only take effect at frame boundaries. It sits between the calculator result/entry logic and the board's anode/segment pins.

## Interface
- DIVISOR, 200000: system-clock cycles per digit slot (500 Hz slot rate at 100 MHz); legal range 4..2^28-1.
- BLANK_CYCLES, 1000: cycles per slot with all anodes off before driving; must be < DIVISOR-1.
- clock_in  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scanning on when high; low forces IDLE.
- load  input  1  single-cycle strobe; captures digits_in/dp_in into the pending buffer.
- digits_in  input  16  four 4-bit hex nibbles; [3:0] is digit 0 (rightmost).
- dp_in  input  4  decimal point per digit, 1 = lit.
- blank_lz  input  1  leading-zero suppression enable.
- anode_out  output  4  digit enables, active-low.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse when digit index wraps 3->0.

## Operation
- Slot counter counts 0..DIVISOR-1 while enable is high. It wraps to 0, and tick asserts for one cycle when it equals DIVISOR-1.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: all outputs off; slot counter and blank counter held at 0. When enable is high, go to BLANK with the index unchanged.
  - BLANK: anodes off; blank counter counts 0..BLANK_CYCLES-1, then go to DRIVE.
  - DRIVE: the anode for the current index is asserted with its segments. On tick, index <= index+1 (mod 4) and state goes to BLANK.
  - In any state, enable low: go to IDLE next cycle and clear both counters. The index and buffers are kept.
- A tick in BLANK cannot occur (BLANK_CYCLES < DIVISOR-1). If the parameters violate this, behaviour is undefined.
- Buffering:
  - load writes pending <= {digits_in, dp_in}.
  - On index wrap 3->0: active <= pending, and frame_done pulses.
  - If load and wrap happen in the same cycle, active takes digits_in/dp_in directly (bypass) and pending is also written.
  - load is accepted in every state, including IDLE.
- Leading-zero suppression, evaluated on active:
  - Digit k (k = 3..1) is blanked when blank_lz is high and active nibbles k..3 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg_out off and dp_out off, but its anode is still asserted.
- Decode: hex 0-F into standard patterns (A, b, C, d, E, F).

## Timing
- Reset values: anode_out=4'b1111, seg_out=7'b1111111, dp_out=1, frame_done=0, index=0, pending=active=0, state=IDLE, counters=0.
- anode_out, seg_out, dp_out and frame_done are registered. They reflect the state/index of the previous cycle: one cycle of latency.
- From enable rising in IDLE, the first anode asserts at cycle 1+BLANK_CYCLES+1.
- Each slot is exactly DIVISOR cycles once running, since the slot counter is free-running and independent of state. Digit on-time is DIVISOR-BLANK_CYCLES cycles, except the first slot after IDLE.
- Reset mid-frame: all registers return to reset values on the next edge. A load in the same cycle as reset is dropped.

## Structure
- Shared package `display_pkg`: segment pattern constants for 0-F, SEG_OFF=7'h7F, ANODE_OFF=4'hF, state encoding localparams, NUM_DIGITS=4.
- Sub-module `hex_to_seg`: combinational nibble -> active-low 7-bit pattern. It is instantiated once on the muxed active nibble.
- Top contains the slot counter, blank counter, FSM, index, pending/active buffers, and output registers.

## Test plan
All scenarios use DIVISOR=8, BLANK_CYCLES=2.
- Reset then idle: assert reset for 2 cycles with enable=0 -> anode_out=1111, seg_out=7F, dp_out=1, frame_done=0 held indefinitely.
- Basic scan: load digits_in=16'h1234, enable=1 -> anodes 1110,1101,1011,0111 each asserted 6 cycles with 2-cycle gaps. Segments read 4,3,2,1, but only after the first wrap, because pre-wrap active=0 shows 0000. frame_done pulses every 32 cycles.
- Buffer boundary: load 16'h00AB mid-frame -> the old value keeps showing until the wrap. load coincident with the wrap cycle -> the new value is shown in slot 0 of the next frame.
- Leading zeros: active=16'h0050, blank_lz=1 -> digits 3 and 2 are blank (seg 7F, anode on), digit 1 shows 5, digit 0 shows 0. With 16'h0000, only digit 0 shows 0.
- Enable drop: deassert enable during DRIVE of digit 2 -> next output cycle all anodes off. Re-enable -> digit 2 resumes after 2 blank cycles.
- Reset mid-frame: reset during DRIVE of digit 3 with pending loaded -> outputs return to reset values, and active/pending=0 after re-enable.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns, idle levels for the anode/segment pins and the scan FSM encoding.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a}: a 0 bit lights that segment.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_BLANK = 2'd1;
    localparam logic [1:0] STATE_DRIVE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        BLANK = STATE_BLANK,
        DRIVE = STATE_DRIVE
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit common-anode scan controller with dead-time blanking,
// frame-synchronous double buffering and leading-zero suppression.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIVISOR      = 200000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  anode_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic        frame_done
);

    localparam int CNT_W = 28;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] blank_cnt;
    logic [1:0]       index;
    logic [15:0]      pending_digits;
    logic [3:0]       pending_dp;
    logic [15:0]      active_digits;
    logic [3:0]       active_dp;

    logic             tick;
    logic             driving;
    logic             wrap;
    logic [3:0]       zero_from;
    logic             digit_blank;
    logic [3:0]       cur_nibble;
    logic             cur_dp;
    logic [6:0]       dec_seg;

    assign tick    = (slot_cnt == SLOT_LAST);
    assign driving = enable && (state == DRIVE);
    assign wrap    = driving && tick && (index == 2'd3);

    // zero_from[k]: nibbles k..3 of the active value are all zero; digit 0 is never blanked.
    assign zero_from[3] = (active_digits[15:12] == 4'h0);
    assign zero_from[2] = zero_from[3] && (active_digits[11:8] == 4'h0);
    assign zero_from[1] = zero_from[2] && (active_digits[7:4] == 4'h0);
    assign zero_from[0] = 1'b0;
    assign digit_blank  = blank_lz && zero_from[index];

    assign cur_nibble = active_digits[{index, 2'b00} +: 4];
    assign cur_dp     = active_dp[index];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = BLANK;
                BLANK:   if (blank_cnt == BLANK_LAST) state_next = DRIVE;
                DRIVE:   if (tick) state_next = BLANK;
                default: state_next = IDLE;
            endcase
        end
    end

    // The slot counter ignores BLANK/DRIVE so every slot is exactly DIVISOR cycles.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            slot_cnt  <= '0;
            blank_cnt <= '0;
            index     <= 2'd0;
        end else begin
            if (!enable || state == IDLE || tick) begin
                slot_cnt <= '0;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (enable && state == BLANK && blank_cnt != BLANK_LAST) begin
                blank_cnt <= blank_cnt + 1'b1;
            end else begin
                blank_cnt <= '0;
            end

            if (driving && tick) begin
                index <= index + 2'd1;
            end
        end
    end

    // A load landing on the wrap cycle bypasses straight into the active buffer.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            pending_digits <= '0;
            pending_dp     <= '0;
            active_digits  <= '0;
            active_dp      <= '0;
        end else begin
            if (load) begin
                pending_digits <= digits_in;
                pending_dp     <= dp_in;
            end
            if (wrap) begin
                active_digits <= load ? digits_in : pending_digits;
                active_dp     <= load ? dp_in : pending_dp;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            anode_out  <= ANODE_OFF;
            seg_out    <= SEG_OFF;
            dp_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (driving) begin
                anode_out <= ~(4'b0001 << index);
                seg_out   <= digit_blank ? SEG_OFF : dec_seg;
                dp_out    <= digit_blank | ~cur_dp;
            end else begin
                anode_out <= ANODE_OFF;
                seg_out   <= SEG_OFF;
                dp_out    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: table-driven frame checks, hand-written corner
// sequences and randomized traffic against a timing-arithmetic reference model.
module tb_display_scan_controller;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  anode_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clock_in = ~clock_in;

    display_scan_controller #(
        .DIVISOR      (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .anode_out  (anode_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    // Lit-segment masks (1 = on), inverted for the common-anode pins.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    function automatic logic [3:0] ref_anode(input int k);
        case (k)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Reference model: position in the run is plain arithmetic on the cycle count
    // since scanning (re)started; digit = start digit + elapsed slots.
    bit          m_run;
    int          m_r;
    int          m_base;
    logic [15:0] m_act_dig, m_pend_dig;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_frame;

    int          m_p, m_cur;
    logic        m_drive, m_wrap, m_blanked;
    logic [3:0]  m_nib;

    assign m_p       = m_r % DIV;
    assign m_cur     = (m_base + m_r / DIV) % 4;
    assign m_drive   = m_run && enable && (m_p >= BLK);
    assign m_wrap    = m_run && enable && (m_p == DIV - 1) && (m_cur == 3);
    assign m_nib     = 4'(m_act_dig >> (4 * m_cur));
    assign m_blanked = blank_lz && (m_cur != 0) && ((m_act_dig >> (4 * m_cur)) == 16'h0);

    always @(posedge clock_in) begin
        if (reset) begin
            m_run      <= 1'b0;
            m_r        <= 0;
            m_base     <= 0;
            m_act_dig  <= '0;
            m_act_dp   <= '0;
            m_pend_dig <= '0;
            m_pend_dp  <= '0;
            exp_anode  <= 4'hF;
            exp_seg    <= 7'h7F;
            exp_dp     <= 1'b1;
            exp_frame  <= 1'b0;
        end else begin
            exp_anode <= m_drive ? ref_anode(m_cur) : 4'hF;
            exp_seg   <= (m_drive && !m_blanked) ? ref_seg(m_nib) : 7'h7F;
            exp_dp    <= (m_drive && !m_blanked) ? ~m_act_dp[m_cur] : 1'b1;
            exp_frame <= m_wrap;
            if (m_wrap) begin
                m_act_dig <= load ? digits_in : m_pend_dig;
                m_act_dp  <= load ? dp_in : m_pend_dp;
            end
            if (load) begin
                m_pend_dig <= digits_in;
                m_pend_dp  <= dp_in;
            end
            if (!enable) begin
                if (m_run) m_base <= m_cur;
                m_run <= 1'b0;
                m_r   <= 0;
            end else if (!m_run) begin
                m_run <= 1'b1;
                m_r   <= 0;
            end else begin
                m_r <= (m_r == 4 * DIV - 1) ? 0 : m_r + 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle is compared against the model once checking is armed.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock_in);
            if (check_en) begin
                check_output("model_anode", {4'h0, anode_out}, {4'h0, exp_anode});
                check_output("model_seg",   {1'b0, seg_out},   {1'b0, exp_seg});
                check_output("model_dp",    {7'h0, dp_out},    {7'h0, exp_dp});
                check_output("model_frame", {7'h0, frame_done}, {7'h0, exp_frame});
            end
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] an, input logic [6:0] sg, input logic d);
        check_output({name, "_anode"}, {4'h0, anode_out}, {4'h0, an});
        check_output({name, "_seg"},   {1'b0, seg_out},   {1'b0, sg});
        check_output({name, "_dp"},    {7'h0, dp_out},    {7'h0, d});
    endtask

    task automatic expect_off(input string name);
        expect_out(name, 4'hF, 7'h7F, 1'b1);
        check_output({name, "_frame"}, {7'h0, frame_done}, 8'h00);
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 80) begin
            step(1);
            n++;
        end
        check_output({name, "_frame_seen"}, {7'h0, frame_done}, 8'h01);
    endtask

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h00AB, 4'b0100, 1'b0, {7'h40, 7'h40, 7'h08, 7'h03}, 4'b1011};
        vecs[2] = '{16'h0050, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[4] = '{16'hCDEF, 4'b1000, 1'b1, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b0111};
        vecs[5] = '{16'h0907, 4'b0010, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h78}, 4'b1101};
        vecs[6] = '{16'h8006, 4'b0000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h02}, 4'b1111};

        reset = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
        digits_in = '0; dp_in = '0;
        step(2);
        check_en = 1'b1;
        reset = 1'b0;

        $display("[TB] reset then idle");
        for (int i = 0; i < 4; i++) begin
            expect_off("idle");
            step(1);
        end

        $display("[TB] basic scan start-up latency");
        apply_stimulus(16'h1234, 4'h0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_off("startup_gap");
        end
        step(1);
        expect_out("first_anode", 4'b1110, 7'h40, 1'b1);

        $display("[TB] frame vectors");
        for (int v = 0; v < 7; v++) begin
            blank_lz = vecs[v].lz;
            apply_stimulus(vecs[v].digits, vecs[v].dp);
            wait_frame("vec");
            step(5);
            for (int k = 0; k < 4; k++) begin
                if (k != 0) step(8);
                expect_out($sformatf("vec%0d_slot%0d", v, k), ref_anode(k),
                           vecs[v].seg[7*k +: 7], vecs[v].dpo[k]);
            end
        end

        $display("[TB] buffer boundary");
        blank_lz = 1'b0;
        wait_frame("bound");
        step(3);
        apply_stimulus(16'h00AB, 4'h0);
        step(9);
        expect_out("old_slot1", 4'b1101, 7'h40, 1'b1);
        step(16);
        expect_out("old_slot3", 4'b0111, 7'h00, 1'b1);
        wait_frame("bound2");
        step(5);
        expect_out("new_slot0", 4'b1110, 7'h03, 1'b1);
        step(26);
        apply_stimulus(16'h4321, 4'b0001);
        check_output("load_on_wrap_frame", {7'h0, frame_done}, 8'h01);
        step(5);
        expect_out("bypass_slot0", 4'b1110, 7'h79, 1'b0);

        $display("[TB] enable drop");
        step(15);
        expect_out("before_drop", 4'b1011, 7'h30, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            expect_off("dropped");
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_off("resume_gap");
        end
        step(1);
        expect_out("resume_digit2", 4'b1011, 7'h30, 1'b1);

        $display("[TB] reset mid-frame");
        apply_stimulus(16'h5678, 4'hF);
        step(7);
        expect_out("before_reset", 4'b0111, 7'h19, 1'b1);
        reset = 1'b1; load = 1'b1; digits_in = 16'h9999; dp_in = 4'hF;
        step(1);
        reset = 1'b0; load = 1'b0;
        expect_off("after_reset");
        step(3);
        step(1);
        expect_out("post_reset_slot0", 4'b1110, 7'h40, 1'b1);
        wait_frame("post_reset");
        step(5);
        expect_out("post_reset_pending", 4'b1110, 7'h40, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            reset     = ($urandom_range(0, 499) == 0);
            load      = ($urandom_range(0, 9) == 0);
            digits_in = 16'($urandom) & mask;
            dp_in     = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            step(1);
        end

        reset = 1'b0; load = 1'b0; enable = 1'b0;
        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
